// File: rtl/m6502_bus_pkg.sv
// Shared types and default memory map for the m6502 bus controller.
// Region/state encodings plus the open-bus value returned for unmapped reads.
package m6502_bus_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_ROM,
        REG_IO,
        REG_UNMAPPED
    } region_e;

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        IO_WAIT,
        DONE
    } state_e;

    localparam logic [7:0]  OPEN_BUS         = 8'hFF;
    localparam int          DEF_RAM_AW       = 15;
    localparam int          DEF_ROM_AW       = 13;
    localparam logic [15:0] DEF_ROM_BASE     = 16'hE000;
    localparam logic [7:0]  DEF_IO_PAGE      = 8'hD0;

endpackage

// File: rtl/m6502_bus_decode.sv
// Combinational address decode: cpu address -> target region.
// Priority ROM > I/O page > RAM > unmapped.
module m6502_bus_decode
    import m6502_bus_pkg::*;
#(
    parameter int          RAM_AW   = DEF_RAM_AW,
    parameter logic [15:0] ROM_BASE = DEF_ROM_BASE,
    parameter logic [7:0]  IO_PAGE  = DEF_IO_PAGE
) (
    input  logic [15:0] addr,
    output region_e     region
);

    localparam logic [16:0] RAM_TOP = 17'(1) << RAM_AW;

    always_comb begin
        region = REG_UNMAPPED;
        if (addr >= ROM_BASE)
            region = REG_ROM;
        else if (addr[15:8] == IO_PAGE)
            region = REG_IO;
        else if ({1'b0, addr} < RAM_TOP)
            region = REG_RAM;
    end

endmodule

// File: rtl/m6502_bus_ctrl.sv
// m6502 CPU bus controller: decodes accesses, issues one-cycle target strobes,
// sequences read latency / wait states and returns data with cpu_ready.
// Optional macro BUS_TIMEOUT_EN bounds the wait for io_ack.
module m6502_bus_ctrl
    import m6502_bus_pkg::*;
#(
    parameter int          RAM_AW         = DEF_RAM_AW,
    parameter int          ROM_AW         = DEF_ROM_AW,
    parameter logic [15:0] ROM_BASE       = DEF_ROM_BASE,
    parameter logic [7:0]  IO_PAGE        = DEF_IO_PAGE,
    parameter int          MEM_LATENCY    = 1,
    parameter int          WAIT_STATES    = 0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_rd_req,
    input  logic              cpu_wr_en,
    input  logic [7:0]        cpu_wr_data,
    output logic [7:0]        cpu_rd_data,
    output logic              cpu_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_rd_en,
    output logic              ram_wr_en,
    output logic [7:0]        ram_wr_data,
    input  logic [7:0]        ram_rd_data,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_rd_en,
    input  logic [7:0]        rom_rd_data,
    output logic [7:0]        io_addr,
    output logic              io_rd_req,
    output logic              io_wr_en,
    output logic [7:0]        io_wr_data,
    input  logic [7:0]        io_rd_data,
    input  logic              io_ack,
    output logic              bus_timeout
);

    localparam logic [3:0] MEM_CYCLES = 4'(MEM_LATENCY + WAIT_STATES);

    state_e     state;
    region_e    region;
    logic       rd_from_rom;
    logic [3:0] mem_cnt;

`ifdef BUS_TIMEOUT_EN
    logic [7:0] io_cnt;
`else
    logic [7:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
`endif

    m6502_bus_decode #(
        .RAM_AW   (RAM_AW),
        .ROM_BASE (ROM_BASE),
        .IO_PAGE  (IO_PAGE)
    ) u_decode (
        .addr   (cpu_addr),
        .region (region)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cpu_ready   <= 1'b1;
            cpu_rd_data <= 8'h00;
            ram_addr    <= '0;
            ram_rd_en   <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_wr_data <= 8'h00;
            rom_addr    <= '0;
            rom_rd_en   <= 1'b0;
            io_addr     <= 8'h00;
            io_rd_req   <= 1'b0;
            io_wr_en    <= 1'b0;
            io_wr_data  <= 8'h00;
            bus_timeout <= 1'b0;
            rd_from_rom <= 1'b0;
            mem_cnt     <= 4'd0;
`ifdef BUS_TIMEOUT_EN
            io_cnt      <= 8'd0;
`endif
        end else begin
            // Strobes are single-cycle by construction: cleared every edge unless re-armed.
            ram_rd_en   <= 1'b0;
            ram_wr_en   <= 1'b0;
            rom_rd_en   <= 1'b0;
            io_rd_req   <= 1'b0;
            io_wr_en    <= 1'b0;
            bus_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_wr_en || cpu_rd_req) begin
                        cpu_ready   <= 1'b0;
                        state       <= DONE;
                        rd_from_rom <= (region == REG_ROM);
                        mem_cnt     <= MEM_CYCLES;
                        case (region)
                            REG_RAM: begin
                                ram_addr <= cpu_addr[RAM_AW-1:0];
                                if (cpu_wr_en) begin
                                    ram_wr_en   <= 1'b1;
                                    ram_wr_data <= cpu_wr_data;
                                end else begin
                                    ram_rd_en <= 1'b1;
                                    state     <= MEM_WAIT;
                                end
                            end
                            REG_ROM: begin
                                rom_addr <= cpu_addr[ROM_AW-1:0];
                                if (!cpu_wr_en) begin
                                    rom_rd_en <= 1'b1;
                                    state     <= MEM_WAIT;
                                end
                            end
                            REG_IO: begin
                                io_addr <= cpu_addr[7:0];
                                if (cpu_wr_en) begin
                                    io_wr_en   <= 1'b1;
                                    io_wr_data <= cpu_wr_data;
                                end else begin
                                    io_rd_req <= 1'b1;
                                    state     <= IO_WAIT;
`ifdef BUS_TIMEOUT_EN
                                    io_cnt    <= 8'd0;
`endif
                                end
                            end
                            default: begin
                                if (!cpu_wr_en)
                                    cpu_rd_data <= OPEN_BUS;
                            end
                        endcase
                    end
                end
                MEM_WAIT: begin
                    if (mem_cnt == 4'd0) begin
                        cpu_rd_data <= rd_from_rom ? rom_rd_data : ram_rd_data;
                        cpu_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        mem_cnt <= mem_cnt - 4'd1;
                    end
                end
                IO_WAIT: begin
                    if (io_ack) begin
                        cpu_rd_data <= io_rd_data;
                        cpu_ready   <= 1'b1;
                        state       <= IDLE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (io_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        cpu_rd_data <= OPEN_BUS;
                        bus_timeout <= 1'b1;
                        cpu_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        io_cnt <= io_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m6502_bus_ctrl.sv
// Randomized scoreboard bench for m6502_bus_ctrl: driver pushes expected
// completions, a negedge monitor pops and compares them.
module tb_m6502_bus_ctrl;

    localparam int MEM_LATENCY = 1;
    localparam int WAIT_STATES = 0;
    localparam int TMO         = 8;
    localparam int MEM_RD_LAT  = MEM_LATENCY + WAIT_STATES + 1;

    typedef struct {
        logic [7:0]  data;
        int          lat;
        int          n_ram_rd, n_ram_wr, n_rom_rd, n_io_rd, n_io_wr, n_to;
        logic [15:0] addr;
        logic [7:0]  wdat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rd_req = 1'b0, cpu_wr_en = 1'b0;
    logic [7:0]  cpu_wr_data = '0;
    logic [7:0]  cpu_rd_data;
    logic        cpu_ready;
    logic [14:0] ram_addr;
    logic        ram_rd_en, ram_wr_en;
    logic [7:0]  ram_wr_data;
    logic [7:0]  ram_rd_data = '0;
    logic [12:0] rom_addr;
    logic        rom_rd_en;
    logic [7:0]  rom_rd_data = '0;
    logic [7:0]  io_addr;
    logic        io_rd_req, io_wr_en;
    logic [7:0]  io_wr_data;
    logic [7:0]  io_rd_data = '0;
    logic        io_ack = 1'b0;
    logic        bus_timeout;

    always #5 clk = ~clk;

    m6502_bus_ctrl #(
        .MEM_LATENCY(MEM_LATENCY), .WAIT_STATES(WAIT_STATES), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_rd_req(cpu_rd_req),
        .cpu_wr_en(cpu_wr_en), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
        .cpu_ready(cpu_ready), .ram_addr(ram_addr), .ram_rd_en(ram_rd_en),
        .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
        .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_rd_data(rom_rd_data),
        .io_addr(io_addr), .io_rd_req(io_rd_req), .io_wr_en(io_wr_en),
        .io_wr_data(io_wr_data), .io_rd_data(io_rd_data), .io_ack(io_ack),
        .bus_timeout(bus_timeout)
    );

    // Target device models: synchronous RAM/ROM with one clock read latency.
    logic [7:0] tb_ram [32768];
    logic [7:0] rom_img [8192];
    always @(posedge clk) begin
        if (ram_wr_en) tb_ram[ram_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= tb_ram[ram_addr];
        if (rom_rd_en) rom_rd_data <= rom_img[rom_addr];
    end

    // Reference model state.
    logic [7:0]  ref_ram [int];
    logic [15:0] written [$];
    logic [7:0]  last_rd = 8'h00;
    exp_t        q [$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    // Monitor: accumulate per-transaction observations, compare on ready rise.
    int          m_lat, m_rr, m_rw, m_ro, m_ir, m_iw, m_to;
    logic [15:0] m_addr;
    logic [7:0]  m_wdat;
    logic        prev_rdy = 1'b1;
    logic [7:0]  hold_data = 8'h00;

    task automatic mon_clear();
        m_lat = 0; m_rr = 0; m_rw = 0; m_ro = 0; m_ir = 0; m_iw = 0; m_to = 0;
        m_addr = '0; m_wdat = '0;
    endtask

    initial mon_clear();

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_clear();
            prev_rdy  = 1'b1;
            hold_data = 8'h00;
        end else begin
            if (!cpu_ready) m_lat++;
            if (ram_rd_en) begin m_rr++; m_addr = {1'b0, ram_addr}; end
            if (ram_wr_en) begin m_rw++; m_addr = {1'b0, ram_addr}; m_wdat = ram_wr_data; end
            if (rom_rd_en) begin m_ro++; m_addr = {3'b0, rom_addr}; end
            if (io_rd_req) begin m_ir++; m_addr = {8'h00, io_addr}; end
            if (io_wr_en)  begin m_iw++; m_addr = {8'h00, io_addr}; m_wdat = io_wr_data; end
            if (bus_timeout) m_to++;
            if (cpu_ready && !prev_rdy) begin
                if (q.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rd_data", cpu_rd_data, e.data);
                    chk("latency", m_lat, e.lat);
                    chk("ram_rd_pulses", m_rr, e.n_ram_rd);
                    chk("ram_wr_pulses", m_rw, e.n_ram_wr);
                    chk("rom_rd_pulses", m_ro, e.n_rom_rd);
                    chk("io_rd_pulses", m_ir, e.n_io_rd);
                    chk("io_wr_pulses", m_iw, e.n_io_wr);
                    chk("timeout_pulses", m_to, e.n_to);
                    chk("target_addr", m_addr, e.addr);
                    chk("target_wdata", m_wdat, e.wdat);
                    hold_data = e.data;
                end
                mon_clear();
            end else if (cpu_ready && prev_rdy) begin
                chk("rd_data_stable", cpu_rd_data, hold_data);
            end
            prev_rdy = cpu_ready;
        end
    end

    // One CPU access; io_d = clocks from request edge to io_ack edge (0 = never ack).
    task automatic do_txn(input logic [15:0] a, input logic wr, input logic rd,
                          input logic [7:0] wd, input int io_d, input logic [7:0] iod,
                          input logic spur);
        exp_t e;
        logic io_rd;
        int j;
        e = '{data: last_rd, lat: 1, n_ram_rd: 0, n_ram_wr: 0, n_rom_rd: 0,
              n_io_rd: 0, n_io_wr: 0, n_to: 0, addr: 16'h0, wdat: 8'h00};
        io_rd = 1'b0;
        if (a >= 16'hE000) begin
            if (!wr) begin
                e.data = rom_img[a - 16'hE000]; e.lat = MEM_RD_LAT;
                e.n_rom_rd = 1; e.addr = a - 16'hE000;
            end
        end else if (a[15:8] == 8'hD0) begin
            e.addr = a & 16'h00FF;
            if (wr) begin
                e.n_io_wr = 1; e.wdat = wd;
            end else begin
                io_rd = 1'b1; e.n_io_rd = 1;
                e.lat  = (io_d == 0) ? TMO : io_d;
                e.data = (io_d == 0) ? 8'hFF : iod;
                e.n_to = (io_d == 0) ? 1 : 0;
            end
        end else if (a < 16'h8000) begin
            e.addr = a;
            if (wr) begin
                e.n_ram_wr = 1; e.wdat = wd;
                if (!ref_ram.exists(int'(a))) written.push_back(a);
                ref_ram[int'(a)] = wd;
            end else begin
                e.n_ram_rd = 1; e.lat = MEM_RD_LAT; e.data = ref_ram[int'(a)];
            end
        end else if (!wr) begin
            e.data = 8'hFF;
        end
        last_rd = e.data;
        q.push_back(e);

        @(posedge clk); #1;
        cpu_addr = a; cpu_wr_en = wr; cpu_rd_req = rd; cpu_wr_data = wd;
        @(posedge clk); #1;
        j = 0;
        forever begin
            if (j == 0) begin
                cpu_rd_req = spur & $urandom_range(0, 1);
                cpu_wr_en  = spur & ~cpu_rd_req;
                if (spur) begin cpu_addr = 16'($urandom_range(0, 16'h01FF)); cpu_wr_data = 8'($urandom); end
            end else begin
                cpu_rd_req = 1'b0; cpu_wr_en = 1'b0;
            end
            io_ack = io_rd && (io_d > 0) && (j == io_d - 1);
            io_rd_data = io_ack ? iod : 8'($urandom);
            if (j > 0 && cpu_ready) break;
            if (j > 60) begin
                chk("ready_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
            j++;
        end
        io_ack = 1'b0;
    endtask

    task automatic reset_mid(input logic [15:0] a);
        @(posedge clk); #1;
        cpu_addr = a; cpu_rd_req = 1'b1;
        @(posedge clk); #1;
        cpu_rd_req = 1'b0; reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        last_rd = 8'h00;
        chk("rst_mid_ready", cpu_ready, 1);
        chk("rst_mid_rd_data", cpu_rd_data, 0);
        chk("rst_mid_strobes", {ram_rd_en, ram_wr_en, rom_rd_en, io_rd_req, io_wr_en}, 0);
        io_ack = 1'b1; io_rd_data = 8'hA5;
        @(posedge clk); #1;
        io_ack = 1'b0;
        @(posedge clk); #1;
        chk("late_ack_ready", cpu_ready, 1);
        chk("late_ack_rd_data", cpu_rd_data, 0);
        chk("late_ack_strobes", {ram_rd_en, ram_wr_en, rom_rd_en, io_rd_req, io_wr_en}, 0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom_img[i] = 8'($urandom);
        rom_img[13'h1FFC] = 8'h00;
        rom_img[13'h1FFD] = 8'hE0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", cpu_ready, 1);
        chk("reset_rd_data", cpu_rd_data, 0);
        chk("reset_strobes", {ram_rd_en, ram_wr_en, rom_rd_en, io_rd_req, io_wr_en, bus_timeout}, 0);
        chk("reset_addrs", {ram_addr, rom_addr, io_addr, ram_wr_data, io_wr_data}, 0);
        reset_n = 1'b1;

        do_txn(16'hFFFC, 0, 1, 8'h00, 1, 8'h00, 0);
        do_txn(16'hFFFD, 0, 1, 8'h00, 1, 8'h00, 0);
        do_txn(16'h0200, 1, 0, 8'h5A, 1, 8'h00, 0);
        do_txn(16'h0200, 0, 1, 8'h00, 1, 8'h00, 0);
        do_txn(16'hD012, 0, 1, 8'h00, 4, 8'h3C, 0);
        do_txn(16'hD034, 0, 1, 8'h00, 1, 8'h77, 0);
        do_txn(16'h9000, 0, 1, 8'h00, 1, 8'h00, 0);
        do_txn(16'hF000, 1, 0, 8'h99, 1, 8'h00, 0);
        do_txn(16'h0010, 1, 1, 8'hC3, 1, 8'h00, 0);
        do_txn(16'h0010, 0, 1, 8'h00, 1, 8'h00, 0);
        do_txn(16'hD0F0, 1, 0, 8'h42, 1, 8'h00, 0);

        reset_mid(16'h0200);
        reset_mid(16'hD012);

`ifdef BUS_TIMEOUT_EN
        do_txn(16'hD055, 0, 1, 8'h00, 0, 8'h00, 0);
        do_txn(16'hD056, 0, 1, 8'h00, TMO, 8'h6B, 0);
`endif

        for (int n = 0; n < 200; n++) begin
            int kind;
            logic [15:0] a;
            logic wr;
            kind = $urandom_range(0, 4);
            wr = 1'($urandom_range(0, 1));
            case (kind)
                0: a = 16'($urandom_range(0, 16'h7FFF));
                1: a = 16'hE000 + 16'($urandom_range(0, 16'h1FFF));
                2: a = {8'hD0, 8'($urandom)};
                3: a = 16'h8000 + 16'($urandom_range(0, 16'h4FFF));
                default: a = 16'h0;
            endcase
            if (kind == 4) begin
                if (written.size() == 0) wr = 1'b1;
                else a = written[$urandom_range(0, written.size() - 1)];
                if (wr) a = 16'($urandom_range(0, 16'h7FFF));
            end
            do_txn(a, wr, ~wr | 1'($urandom_range(0, 1)), 8'($urandom),
                   $urandom_range(1, 6), 8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                io_ack = 1'b1; io_rd_data = 8'($urandom);
                @(posedge clk); #1;
                io_ack = 1'b0;
            end
        end

        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
